// File: rtl/shift_result_display_if.sv
// Valid/ready handshake bundle between the barrel shifter stage and the result display.
// W is the shifted word width and must match 2**N of the attached display.
interface shift_result_display_if #(
   parameter int W = 8
);
   logic [W-1:0] data_in;
   logic         lr_in;
   logic         data_valid;
   logic         data_ready;

   modport master (
      output data_in,
      output lr_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  lr_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/shift_result_display.sv
// Captures a shifted word plus its direction flag, then scans it as hex onto a 4-digit
// active-low seven-segment display. Optional: SHIFT_DISPLAY_LZ_BLANK_EN blanks leading zeros.
//
// state   | meaning
// S_READY | data_ready=1, next data_valid captures the word
// S_HOLD  | data_ready=0, keeps the word on display until the next frame_end
module shift_result_display #(
   parameter int N        = 3,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   shift_result_display_if.slave bus,
   output logic [3:0]            o_an,
   output logic [6:0]            o_seg,
   output logic                  o_dp
);

   localparam int W      = 2**N;
   localparam int DIGITS = W / 4;
   localparam int PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {
      S_READY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_capture;

   logic [PW-1:0]  r_presc;
   logic [1:0]     r_idx;
   logic           r_upd;
   logic           w_tick;
   logic           w_frame_end;

   logic [W-1:0]   r_disp;
   logic           r_lr;

   logic [3:0]     w_nib;
   logic           w_show;
   logic [3:0]     w_an;
   logic [6:0]     w_seg;
   logic           w_dp;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'b1000000;
         4'h1:    f = 7'b1111001;
         4'h2:    f = 7'b0100100;
         4'h3:    f = 7'b0110000;
         4'h4:    f = 7'b0011001;
         4'h5:    f = 7'b0010010;
         4'h6:    f = 7'b0000010;
         4'h7:    f = 7'b1111000;
         4'h8:    f = 7'b0000000;
         4'h9:    f = 7'b0010000;
         4'hA:    f = 7'b0001000;
         4'hB:    f = 7'b0000011;
         4'hC:    f = 7'b1000110;
         4'hD:    f = 7'b0100001;
         4'hE:    f = 7'b0000110;
         default: f = 7'b0001110;
      endcase
      return f;
   endfunction

   // Slot scan: always four slots per frame, even when fewer digits are driven.
   assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
   assign w_frame_end = w_tick && (r_idx == 2'd3);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
         r_upd   <= 1'b1;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         r_upd <= w_tick;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_READY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_READY: begin
            if (bus.data_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_frame_end) begin
               w_state_nxt = S_READY;
            end
         end
         default: w_state_nxt = S_READY;
      endcase
   end

   assign bus.data_ready = (r_state == S_READY);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_disp <= '0;
         r_lr   <= 1'b0;
      end else if (w_capture) begin
         r_disp <= bus.data_in;
         r_lr   <= bus.lr_in;
      end
   end

   always_comb begin
      w_nib  = 4'(r_disp >> {r_idx, 2'b00});
      w_show = ({1'b0, r_idx} < 3'(DIGITS));
`ifdef SHIFT_DISPLAY_LZ_BLANK_EN
      if ((r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == '0)) begin
         w_show = 1'b0;
      end
`else
`endif
      w_an  = w_show ? ~(4'b0001 << r_idx) : 4'b1111;
      w_seg = w_show ? hex_font(w_nib) : 7'b1111111;
      w_dp  = !((r_idx == 2'd0) && r_lr);
   end

   // Outputs refresh only once per slot, so a capture never tears a digit mid-slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_an  <= 4'b1111;
         o_seg <= 7'b1111111;
         o_dp  <= 1'b1;
      end else if (r_upd) begin
         o_an  <= w_an;
         o_seg <= w_seg;
         o_dp  <= w_dp;
      end
   end

endmodule

// File: tb/tb_shift_result_display.sv
// Directed bench for shift_result_display: reset, scan timing, capture/display, back-pressure,
// capture on frame_end, and 16-bit leading-zero behaviour (both builds of SHIFT_DISPLAY_LZ_BLANK_EN).
module tb_shift_result_display;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] an8, an16;
   logic [6:0] seg8, seg16;
   logic       dp8, dp16;

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;

   always #5 clk = ~clk;

   shift_result_display_if #(.W(8))  bus8 ();
   shift_result_display_if #(.W(16)) bus16 ();

   shift_result_display #(.N(3), .SCAN_DIV(4)) dut8 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus8),
      .o_an  (an8),
      .o_seg (seg8),
      .o_dp  (dp8)
   );

   shift_result_display #(.N(4), .SCAN_DIV(4)) dut16 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus16),
      .o_an  (an16),
      .o_seg (seg16),
      .o_dp  (dp16)
   );

   // Expected values per slot start (samples k = 1, 5, 9, 13, 17 after the second reset release)
   logic [6:0] seg8_tbl [0:4] = '{SEG_0, SEG_A, BLANK, BLANK, SEG_5};
   logic       dp8_tbl  [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef SHIFT_DISPLAY_LZ_BLANK_EN
   logic [3:0] an16_tbl  [0:4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1110};
   logic [6:0] seg16_tbl [0:4] = '{SEG_0, SEG_F, BLANK, BLANK, SEG_0};
`else
   logic [3:0] an16_tbl  [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
   logic [6:0] seg16_tbl [0:4] = '{SEG_0, SEG_F, SEG_0, SEG_0, SEG_0};
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s (k=%0d): observed %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      k++;
   endtask

   function automatic logic [3:0] scan_an8(input int kk);
      int s;
      s = ((kk - 1) / 4) % 4;
      return (s == 0) ? 4'b1110 : (s == 1) ? 4'b1101 : 4'b1111;
   endfunction

   initial begin
      rst              = 1'b1;
      bus8.data_in     = 8'h00;
      bus8.lr_in       = 1'b0;
      bus8.data_valid  = 1'b0;
      bus16.data_in    = 16'h0000;
      bus16.lr_in      = 1'b0;
      bus16.data_valid = 1'b0;

      #1;
      check("rst_an",    16'(an8),  16'(4'b1111));
      check("rst_seg",   16'(seg8), 16'(BLANK));
      check("rst_dp",    16'(dp8),  16'(1'b1));
      check("rst_ready", 16'(bus8.data_ready), 16'(1'b1));

      // First run: capture 8'h12 so the state is HOLD when the mid-slot reset hits.
      repeat (2) @(negedge clk);
      rst             = 1'b0;
      bus8.data_in    = 8'h12;
      bus8.lr_in      = 1'b1;
      bus8.data_valid = 1'b1;
      k = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (k == 1) begin
            check("post_rst_seg", 16'(seg8), 16'(SEG_0));
            check("post_rst_dp",  16'(dp8),  16'(1'b1));
            bus8.data_valid = 1'b0;
         end
         check("scan1_an", 16'(an8), 16'(scan_an8(k)));
      end
      check("pre_rst_ready", 16'(bus8.data_ready), 16'(1'b0));

      // Asynchronous reset mid-slot (an=1101), checked before the next clock edge.
      #2 rst = 1'b1;
      #1;
      check("async_an",    16'(an8),  16'(4'b1111));
      check("async_seg",   16'(seg8), 16'(BLANK));
      check("async_dp",    16'(dp8),  16'(1'b1));
      check("async_ready", 16'(bus8.data_ready), 16'(1'b1));

      // Second run: capture A5/left on dut8 and 00F0 on dut16 right at release.
      @(negedge clk);
      rst              = 1'b0;
      bus8.data_in     = 8'hA5;
      bus8.lr_in       = 1'b1;
      bus8.data_valid  = 1'b1;
      bus16.data_in    = 16'h00F0;
      bus16.lr_in      = 1'b0;
      bus16.data_valid = 1'b1;
      k = 0;
      for (int i = 1; i <= 17; i++) begin
         step();
         check("scan_an",  16'(an8),  16'(scan_an8(k)));
         check("disp_seg", 16'(seg8), 16'(seg8_tbl[(k - 1) / 4]));
         check("disp_dp",  16'(dp8),  16'(dp8_tbl[(k - 1) / 4]));
         if (((k - 1) % 4) == 0) begin
            check("w16_an",  16'(an16),  16'(an16_tbl[(k - 1) / 4]));
            check("w16_seg", 16'(seg16), 16'(seg16_tbl[(k - 1) / 4]));
            check("w16_dp",  16'(dp16),  16'(1'b1));
         end
         if (k == 1) begin
            check("cap_ready", 16'(bus8.data_ready), 16'(1'b0));
            bus8.data_valid  = 1'b0;
            bus16.data_valid = 1'b0;
         end
         if (k == 15) check("hold_ready", 16'(bus8.data_ready), 16'(1'b0));
         if (k == 16) begin
            check("rel_ready", 16'(bus8.data_ready), 16'(1'b1));
            bus8.data_in    = 8'h3C;
            bus8.lr_in      = 1'b0;
            bus8.data_valid = 1'b1;
         end
         if (k == 17) begin
            bus8.data_in = 8'h81;
            bus8.lr_in   = 1'b1;
         end
      end

      // Back-pressure with valid held high, then capture on a frame_end cycle.
      for (int i = 18; i <= 80; i++) begin
         step();
         check("scan2_an", 16'(an8), 16'(scan_an8(k)));
         if (k == 21) check("bp_seg_3c", 16'(seg8), 16'(SEG_3));
         if (k == 31) check("bp_hold_ready", 16'(bus8.data_ready), 16'(1'b0));
         if (k == 32) check("bp_rel_ready",  16'(bus8.data_ready), 16'(1'b1));
         if (k == 33) begin
            check("bp_cap_ready", 16'(bus8.data_ready), 16'(1'b0));
            check("bp_seg_c",     16'(seg8), 16'(SEG_C));
            check("bp_dp_3c",     16'(dp8),  16'(1'b1));
            bus8.data_valid = 1'b0;
         end
         if (k == 37) check("bp_seg_8", 16'(seg8), 16'(SEG_8));
         if (k == 48) check("fe_ready_up", 16'(bus8.data_ready), 16'(1'b1));
         if (k == 49) begin
            check("bp_seg_1", 16'(seg8), 16'(SEG_1));
            check("bp_dp_81", 16'(dp8),  16'(1'b0));
         end
         if (k == 63) begin
            bus8.data_in    = 8'h7E;
            bus8.lr_in      = 1'b0;
            bus8.data_valid = 1'b1;
         end
         if (k >= 64 && k <= 79) check("fe_hold_ready", 16'(bus8.data_ready), 16'(1'b0));
         if (k == 64) bus8.data_valid = 1'b0;
         if (k == 65) begin
            check("fe_seg_e", 16'(seg8), 16'(SEG_E));
            check("fe_dp",    16'(dp8),  16'(1'b1));
         end
         if (k == 69) check("fe_seg_7", 16'(seg8), 16'(SEG_7));
         if (k == 80) check("fe_rel_ready", 16'(bus8.data_ready), 16'(1'b1));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_result_display.md
Name: shift_result_display

Overview:
Downstream consumer of the multi-function barrel shifter output on the Basys3 board. It captures a shifted word and its left/right flag through a valid/ready handshake. It then time-multiplexes the word as hex digits onto the 4-digit active-low seven-segment display. After each capture, it holds the new value for at least one full refresh frame before accepting another.

Parameters:
N, 3, log2 of data width; data width W = 2**N; legal range 2..4
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); minimum 2
DIGITS, (2**N)/4, derived localparam, number of hex digits driven (1..4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  2**N  shifted word from shifter stage
lr_in  input  1  shift direction that produced data_in (1 = left)
data_valid  input  1  data_in/lr_in valid this cycle
data_ready  output  1  block can accept a word this cycle
an  output  4  digit anodes, active-low, an[0] = rightmost digit
seg  output  7  cathodes, active-low, seg[0]=a … seg[6]=g
dp  output  1  decimal point, active-low

Behaviour:
- Reset: rst is asynchronous and active-high; it clears all state immediately, independent of clk.
  - Reset values: disp_reg=0, lr_reg=0, prescaler=0, digit index=0, state=S_READY.
  - Reset outputs: an=4'b1111, seg=7'b1111111, dp=1, data_ready=1.
  - Handshake input is ignored while rst is high. Reset mid-frame or mid-HOLD aborts to S_READY.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (count==SCAN_DIV-1).
  - On each tick, the digit index increments mod 4 (always 4 slots, regardless of DIGITS).
  - frame_end = tick while index==3.
- FSM, two states:
  - S_READY: data_ready=1. When data_valid=1, transfer occurs: disp_reg<=data_in, lr_reg<=lr_in, next state S_HOLD.
  - S_HOLD: data_ready=0; data_valid is ignored (no capture). Transitions to S_READY on the cycle after frame_end.
  - Transfer and frame_end in the same cycle: the transfer is taken, and HOLD lasts until the next frame_end (no shortened hold).
  - data_ready is decoded from state (no combinational path from data_valid).
- Digit output, registered with one-cycle latency after the index changes:
  - Slot i < DIGITS: an bit i=0, all other an bits=1. seg = hex font of disp_reg[4i+3:4i].
  - Slot i >= DIGITS: an=4'b1111, seg=7'b1111111.
  - dp=0 only in slot 0 when lr_reg=1; otherwise dp=1.
- Hex font, g..a order, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- A newly captured value appears on the display at the first slot update after capture; there is no tearing within a slot.

Optional Feature:
Macro SHIFT_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any slot i>0 whose nibble and all higher nibbles of disp_reg are zero drives an=4'b1111 and seg=7'b1111111. Slot 0 is always shown. dp behaviour is unchanged.
- Undefined: every slot i<DIGITS shows its nibble, including leading zeros.

Test Plan:
All scenarios use SCAN_DIV=4 unless noted.
1. Reset: assert rst asynchronously mid-slot while an=1101 -> an=1111, seg=1111111, dp=1, data_ready=1 with no clk edge; after release, the slot-0 digit shows "0".
2. Capture and display (N=3): data_in=8'hA5, lr_in=1, one-cycle valid -> slot0 shows seg=0010010 with dp=0; slot1 shows seg=0001000 with dp=1; slots 2,3 drive an=1111.
3. Scan timing: run free with no reset -> an sequence 1110, 1101, then two blank slots, repeating; each slot lasts exactly 4 clks; frame = 16 clks.
4. HOLD back-pressure: hold data_valid=1 with 8'h3C, then 8'h81 -> 8'h3C is captured; data_ready=0 until the cycle after the next index 3→0 tick; 8'h81 is captured on the first ready cycle; 8'h81 offered during HOLD is not captured earlier.
5. Simultaneous transfer and frame_end: assert valid on the frame_end cycle -> captured, data_ready stays low for the full following frame (16 clks).
6. N=4, data_in=16'h00F0:
   - With SHIFT_DISPLAY_LZ_BLANK_EN defined -> slots 3,2 blank; slot1=F (0001110); slot0=0 (1000000).
   - With the macro undefined -> slots show 0, 0, F, 0.
